// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard playback controller: character codes,
// FSM state type and the announceable-character classifier.
package kbd_pkg;

  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_D     = 8'h44;
  localparam logic [7:0] CH_F     = 8'h46;
  localparam logic [7:0] CH_B     = 8'h42;
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_EQ    = 8'h3D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ANNOUNCE,
    ST_WAIT_AUDIO,
    ST_DONE
  } kbd_state_t;

  function automatic logic is_announceable(input logic [7:0] c);
    return ((c >= CH_0) && (c <= CH_9)) || (c == CH_PLUS) ||
           (c == CH_MINUS) || (c == CH_EQ);
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous keystroke FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module kbd_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  // A push into a full FIFO is still accepted when the head leaves the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/keyboard_playback_ctrl.sv
// Keystroke-driven playback controller: buffers keystrokes, applies transport
// commands and hands announceable characters to the audio path.
module keyboard_playback_ctrl
  import kbd_pkg::*;
#(
  parameter int unsigned CHAR_W         = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          read_keyboard_flag,
  input  logic [CHAR_W-1:0]             character,
  input  logic                          audio_done_flag,
  output logic [CHAR_W-1:0]             valid_char,
  output logic                          read_addr_start,
  output logic                          error_flag,
  output logic                          play_en,
  output logic                          direction,
  output logic                          restart,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          led0
);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

  kbd_state_t          state, state_n;
  logic [CHAR_W-1:0]   head, hold;
  logic                fifo_full, fifo_empty, fifo_pop, overflow;
  logic [TW-1:0]       tcnt;
  logic                timeout_hit;
  logic [7:0]          hold_lo;
  logic                hi_zero, is_cmd, is_ann;
  logic [CHAR_W-1:0]   vc_d;
  logic                ras_d, err_d, pe_d, dir_d, rs_d, led_d;

  assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
  assign overflow = read_keyboard_flag && fifo_full && !fifo_pop;

  kbd_fifo #(.W(CHAR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push    (read_keyboard_flag),
    .pop     (fifo_pop),
    .wr_data (character),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Wider character codes only match when their upper bits are clear
  assign hold_lo = hold[7:0];
  assign hi_zero = ((hold >> 8) == '0);
  assign is_cmd  = hi_zero && (hold_lo inside {CH_E, CH_D, CH_F, CH_B, CH_R});
  assign is_ann  = hi_zero && is_announceable(hold_lo);

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == ST_WAIT_AUDIO) && (tcnt == T_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:       if (!fifo_empty) state_n = ST_DECODE;
      ST_DECODE:     state_n = is_ann ? ST_ANNOUNCE : ST_IDLE;
      ST_ANNOUNCE:   state_n = ST_WAIT_AUDIO;
      ST_WAIT_AUDIO: if (audio_done_flag || timeout_hit) state_n = ST_DONE;
      ST_DONE:       state_n = ST_IDLE;
      default:       state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    vc_d  = valid_char;
    ras_d = read_addr_start;
    err_d = overflow;
    pe_d  = play_en;
    dir_d = direction;
    rs_d  = 1'b0;
    led_d = led0;
    case (state)
      ST_DECODE: begin
        if (is_cmd) begin
          led_d = ~led0;
          case (hold_lo)
            CH_E:    pe_d = 1'b1;
            CH_D:    pe_d = 1'b0;
            CH_F:    dir_d = 1'b1;
            CH_B:    dir_d = 1'b0;
            default: begin
              rs_d  = 1'b1;
              dir_d = 1'b1;
              pe_d  = 1'b1;
            end
          endcase
        end else if (is_ann) begin
          led_d = ~led0;
          vc_d  = hold;
          ras_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      ST_WAIT_AUDIO: if (!audio_done_flag && timeout_hit) err_d = 1'b1;
      ST_DONE: begin
        vc_d  = '0;
        ras_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_char      <= '0;
      read_addr_start <= 1'b0;
      error_flag      <= 1'b0;
      play_en         <= 1'b0;
      direction       <= 1'b1;
      restart         <= 1'b0;
      led0            <= 1'b0;
      hold            <= '0;
      tcnt            <= '0;
    end else begin
      valid_char      <= vc_d;
      read_addr_start <= ras_d;
      error_flag      <= err_d;
      play_en         <= pe_d;
      direction       <= dir_d;
      restart         <= rs_d;
      led0            <= led_d;
      if (fifo_pop) hold <= head;
      if (state == ST_ANNOUNCE)        tcnt <= '0;
      else if (state == ST_WAIT_AUDIO) tcnt <= tcnt + 1'b1;
    end
  end

endmodule
